dmem_lsu: RTL
=============

// Module: dmem_lsu
// PURPOSE
// - Load/store sequencer between the execute stage and the data-memory bus.
// - Consumes the 4-bit byte-lane mask from the memory mask-control stage and aligns store data to its lanes.
// - Runs a req/ack transaction to data memory, then extracts and sign/zero-extends load data.
// - Returns one result per accepted request; misaligned or timed-out accesses return a fault instead.
// PARAMETERS
// - TIMEOUT_CYCLES  16  cycles in REQ without mem_ack before the access is abandoned with out_fault=1 (>=2)
// PORTS
// - clk           in   1   single clock, all state on rising edge
// - rst           in   1   synchronous, active-high reset
// - in_valid      in   1   request valid from execute
// - in_ready      out  1   request accepted when in_valid & in_ready
// - in_is_store   in   1   1=store, 0=load
// - in_funct3     in   3   [1:0] size 00=B 01=H 10=W; [2]=unsigned load
// - in_addr       in   32  byte address
// - in_wdata      in   32  store data, right-justified
// - in_mask       in   4   byte-lane mask from mask control for this funct3/addr[1:0]
// - mem_req       out  1   bus request, held until mem_ack
// - mem_we        out  1   write enable, valid with mem_req
// - mem_addr      out  32  word address {in_addr[31:2],2'b00}
// - mem_wmask     out  4   registered in_mask; 4'b0000 for loads
// - mem_wdata     out  32  in_wdata << (8*addr[1:0])
// - mem_ack       in   1   completes the request; mem_rdata valid in the same cycle
// - mem_rdata     in   32  word read data
// - out_valid     out  1   one-cycle result strobe
// - out_rdata     out  32  extended load data; 0 for stores and faults
// - out_fault     out  1   misaligned access or timeout, valid with out_valid
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, mem_req=0, mem_we=0, mem_wmask=0, out_valid=0, out_fault=0, out_rdata=0, timeout cnt=0.
// - FSM IDLE -> REQ: on accept when aligned. All request fields are registered on accept.
// - FSM IDLE -> RESP: on accept when misaligned. No bus activity.
// - FSM REQ -> RESP: on mem_ack, or when cnt == TIMEOUT_CYCLES-1.
// - FSM RESP -> IDLE: always, after one cycle.
// - in_ready is 1 only in IDLE. No request is accepted in REQ or RESP.
// - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. Size 11 is treated as W.
// - mem_req/mem_we/mem_addr/mem_wmask/mem_wdata are registered and stable for the whole of REQ.
// - mem_req falls in the cycle after ack. An ack seen with mem_req=0 is ignored.
// - Latency: accept at cycle 0 -> mem_req=1 at cycle 1. Ack at cycle k (k>=1) -> out_valid at k+1.
// - Latency: misaligned accept at cycle 0 -> out_valid=1 and out_fault=1 at cycle 1.
// - Load data is captured on ack, shifted right by 8*addr[1:0] and truncated to size.
// - Extension: funct3[2]=0 sign-extends; funct3[2]=1 zero-extends. W ignores funct3[2].
// - Timeout: cnt counts REQ cycles, cleared on REQ entry. At expiry mem_req drops and out_fault=1.
// - Timeout: a mem_ack arriving in the expiry cycle wins; the access completes normally with no fault.
// - out_valid, out_fault and out_rdata are registered. out_fault and out_rdata return to 0 when out_valid=0.
// - Reset mid-operation: the next edge forces the reset values and abandons the transaction.
// - Reset mid-operation: no out_valid is emitted for the abandoned transaction.
// STRUCTURE
// - Shared include dmem_defs.vh: funct3 size/unsigned encodings; FSM state encodings IDLE/REQ/RESP.
// - One sub-module, load_extend: combinational (rdata, pos, funct3) -> extended 32-bit result.
// - FSM, timeout counter and registers stay in dmem_lsu.
// TESTING
// - SW addr 0x104, wdata 0xDEADBEEF, mask 1111, ack at cycle 3.
//   -> mem_addr 0x104, wmask 1111, wdata 0xDEADBEEF, out_valid at cycle 4, rdata 0.
// - SB addr 0x203, wdata 0x000000A5, mask 1000.
//   -> mem_wdata 0xA5000000, wmask 1000, mem_addr 0x200.
// - LB addr 0x101, rdata 0x0000_80_00 -> out_rdata 0xFFFFFF80.
// - LBU at the same address and rdata -> out_rdata 0x00000080.
// - LHU addr 0x102, rdata 0xBEEF0000 -> out_rdata 0x0000BEEF.
// - LW addr 0x102 -> no mem_req, out_valid and out_fault at cycle 1, in_ready=1 at cycle 2.
// - LH addr 0x101 -> same fault response as LW misaligned.
// - Load with mem_ack never asserted -> mem_req high exactly TIMEOUT_CYCLES cycles, then out_fault=1.
// - Load with ack in the expiry cycle -> normal completion, out_fault=0.
// - rst asserted in REQ -> mem_req=0 next cycle, no out_valid, next request accepted normally.
// - Back-to-back requests with in_valid held high -> one accept per transaction.
//   -> in_ready low in REQ and RESP, no dropped or duplicated results.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states,
// the registered request payload and the alignment rule.
package dmem_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam int unsigned F3_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] pos;
    } req_t;

    // Size 11 falls into the word rule.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] pos);
        case (funct3[1:0])
            SIZE_B:  return 1'b0;
            SIZE_H:  return pos[0];
            default: return pos != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_load_extend.sv
// Combinational load-data alignment: shift the read word down to the accessed lane,
// truncate to the access size and sign- or zero-extend to 32 bits.
module load_extend
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  pos,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic        is_unsigned;

    always_comb begin
        shifted     = rdata >> {pos, 3'b000};
        is_unsigned = funct3[F3_UNSIGNED_BIT];
        case (funct3[1:0])
            SIZE_B:  result = is_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = is_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer: accepts one request from execute, runs a req/ack bus
// transaction (or faults on misalignment/timeout) and returns one registered result.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_mask,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_fault
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    req_t              req, req_next;
    logic [31:0]       mem_addr_next, mem_wdata_next;
    logic [3:0]        mem_wmask_next;
    logic              mem_we_next;
    logic              out_fault_next;
    logic [31:0]       out_rdata_next;
    logic              accept_c, misalign_c, expire_c;
    logic [31:0]       ext_c;

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .pos    (req.pos),
        .funct3 (req.funct3),
        .result (ext_c)
    );

    // Next-state and next-register values.
    always_comb begin
        state_next     = state;
        cnt_next       = '0;
        req_next       = req;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        mem_wmask_next = mem_wmask;
        mem_we_next    = mem_we;
        out_fault_next = 1'b0;
        out_rdata_next = '0;
        accept_c       = in_valid & in_ready;
        misalign_c     = misaligned(in_funct3, in_addr[1:0]);
        expire_c       = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    req_next.is_store = in_is_store;
                    req_next.funct3   = in_funct3;
                    req_next.pos      = in_addr[1:0];
                    if (misalign_c) begin
                        state_next     = ST_RESP;
                        out_fault_next = 1'b1;
                    end else begin
                        state_next     = ST_REQ;
                        mem_addr_next  = {in_addr[31:2], 2'b00};
                        mem_wdata_next = in_wdata << {in_addr[1:0], 3'b000};
                        mem_wmask_next = in_is_store ? in_mask : 4'b0000;
                        mem_we_next    = in_is_store;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (mem_ack) begin
                    state_next     = ST_RESP;
                    mem_we_next    = 1'b0;
                    mem_wmask_next = 4'b0000;
                    out_rdata_next = req.is_store ? 32'd0 : ext_c;
                end else if (expire_c) begin
                    state_next     = ST_RESP;
                    mem_we_next    = 1'b0;
                    mem_wmask_next = 4'b0000;
                    out_fault_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req       <= '0;
            in_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wmask <= 4'b0000;
            mem_wdata <= '0;
            out_valid <= 1'b0;
            out_fault <= 1'b0;
            out_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req       <= req_next;
            in_ready  <= (state_next == ST_IDLE);
            mem_req   <= (state_next == ST_REQ);
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wmask <= mem_wmask_next;
            mem_wdata <= mem_wdata_next;
            out_valid <= (state_next == ST_RESP);
            out_fault <= out_fault_next;
            out_rdata <= out_rdata_next;
        end
    end

endmodule
